// File: rtl/edge_mag_pipe.sv
// edge_mag_pipe: two-stage pipelined Sobel gradient magnitude (|gx|+|gy|)
// with saturation, binary-edge or gated-magnitude output per lane, a per-beat
// edge popcount and a saturating running edge counter. Valid/ready on both
// sides; in_ready depends only on pipeline occupancy and out_ready.
module edge_mag_pipe #(
  parameter int GRAD_W = 11,
  parameter int OUT_W  = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 32,
  localparam int BE_W  = $clog2(LANES + 1)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*GRAD_W-1:0]   gx,
  input  logic [LANES*GRAD_W-1:0]   gy,
  input  logic [OUT_W-1:0]          threshold,
  input  logic [1:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    pix_out,
  output logic [BE_W-1:0]           beat_edges,
  input  logic                      clr_count,
  output logic [CNT_W-1:0]          edge_total
);

  // One extra bit so that |-2^(W-1)| + |-2^(W-1)| = 2^W never wraps.
  localparam int SUM_W = GRAD_W + 1;
  localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'((2 ** OUT_W) - 1);

  logic                     w_adv1;
  logic                     w_adv2;
  logic                     w_hs;
  logic [LANES*SUM_W-1:0]   w_sum;
  logic [LANES-1:0]         w_edge;
  logic [LANES*OUT_W-1:0]   w_sat;
  logic [LANES*OUT_W-1:0]   w_pix;
  logic [BE_W-1:0]          w_edgeCnt;
  logic [CNT_W:0]           w_totalSum;

  logic                     r_s1Valid;
  logic [LANES*SUM_W-1:0]   r_s1Sum;
  logic [OUT_W-1:0]         r_s1Thr;
  logic [1:0]               r_s1Mode;
  logic                     r_s2Valid;
  logic [LANES*OUT_W-1:0]   r_s2Pix;
  logic [BE_W-1:0]          r_s2Edges;
  logic [CNT_W-1:0]         r_total;

  // Two's-complement magnitude kept in GRAD_W unsigned bits; the most
  // negative value maps to 2^(GRAD_W-1), which still fits.
  function automatic logic [GRAD_W-1:0] absVal(input logic [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? -g : g;
  endfunction

  assign w_adv2     = !r_s2Valid || out_ready;
  assign w_adv1     = !r_s1Valid || w_adv2;
  assign in_ready   = w_adv1;
  assign w_hs       = r_s2Valid && out_ready;
  assign w_totalSum = {1'b0, r_total} + (CNT_W + 1)'(r_s2Edges);

  assign out_valid  = r_s2Valid;
  assign pix_out    = r_s2Pix;
  assign beat_edges = r_s2Edges;
  assign edge_total = r_total;

  // Per-lane full-width magnitude sum feeding stage 1.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum[i*SUM_W +: SUM_W] = {1'b0, absVal(gx[i*GRAD_W +: GRAD_W])}
                              + {1'b0, absVal(gy[i*GRAD_W +: GRAD_W])};
    end
  end

  // Saturation, strict threshold compare on the full sum, mode select and
  // popcount, all from the stage-1 snapshot so mid-stream changes to
  // threshold/mode cannot touch beats already accepted.
  always_comb begin
    w_edge    = '0;
    w_sat     = '0;
    w_pix     = '0;
    w_edgeCnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_edge[i] = r_s1Sum[i*SUM_W +: SUM_W] > SUM_W'(r_s1Thr);
      w_sat[i*OUT_W +: OUT_W] = (r_s1Sum[i*SUM_W +: SUM_W] > PIX_MAX)
                              ? {OUT_W{1'b1}} : r_s1Sum[i*SUM_W +: OUT_W];
      case (r_s1Mode)
        2'b01:   w_pix[i*OUT_W +: OUT_W] = w_edge[i] ? {OUT_W{1'b1}} : '0;
        2'b10:   w_pix[i*OUT_W +: OUT_W] = w_edge[i] ? w_sat[i*OUT_W +: OUT_W] : '0;
        default: w_pix[i*OUT_W +: OUT_W] = w_sat[i*OUT_W +: OUT_W];
      endcase
      w_edgeCnt = w_edgeCnt + BE_W'(w_edge[i]);
    end
  end

  // Stage 1: capture sums and the beat's own threshold/mode when it can move.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1Valid <= 1'b0;
      r_s1Sum   <= '0;
      r_s1Thr   <= '0;
      r_s1Mode  <= '0;
    end else if (w_adv1) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Sum  <= w_sum;
        r_s1Thr  <= threshold;
        r_s1Mode <= mode;
      end
    end
  end

  // Stage 2: final pixels and edge count, held while downstream stalls.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s2Valid <= 1'b0;
      r_s2Pix   <= '0;
      r_s2Edges <= '0;
    end else if (w_adv2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Pix   <= w_pix;
        r_s2Edges <= w_edgeCnt;
      end
    end
  end

  // Saturating running edge count; a clear coinciding with a handshake
  // restarts the count from that beat's edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_total <= '0;
    end else if (clr_count) begin
      r_total <= w_hs ? CNT_W'(r_s2Edges) : '0;
    end else if (w_hs) begin
      r_total <= w_totalSum[CNT_W] ? {CNT_W{1'b1}} : w_totalSum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_edge_mag_pipe.sv
// tb_edge_mag_pipe: table-driven single-beat vectors plus directed sequences
// for streaming with backpressure, late threshold/mode change, mid-flight
// reset and edge counter saturation/clear. Counter is narrowed to 6 bits so
// saturation is reachable.
module tb_edge_mag_pipe;
  localparam int GRAD_W = 11;
  localparam int OUT_W  = 8;
  localparam int LANES  = 4;
  localparam int CNT_W  = 6;
  localparam int BE_W   = 3;
  localparam int CNT_MAX = 63;

  typedef struct {
    logic [LANES*GRAD_W-1:0] gx;
    logic [LANES*GRAD_W-1:0] gy;
    logic [OUT_W-1:0]        thr;
    logic [1:0]              mode;
    logic [LANES*OUT_W-1:0]  pix;
    logic [BE_W-1:0]         edges;
  } vec_t;

  logic                    clk;
  logic                    n_rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*GRAD_W-1:0] gx;
  logic [LANES*GRAD_W-1:0] gy;
  logic [OUT_W-1:0]        threshold;
  logic [1:0]              mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*OUT_W-1:0]  pix_out;
  logic [BE_W-1:0]         beat_edges;
  logic                    clr_count;
  logic [CNT_W-1:0]        edge_total;

  int passCount = 0;
  int checkCount = 0;
  int expTotal = 0;
  vec_t vecs[7];

  edge_mag_pipe #(.GRAD_W(GRAD_W), .OUT_W(OUT_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .gx(gx), .gy(gy), .threshold(threshold), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .pix_out(pix_out),
    .beat_edges(beat_edges), .clr_count(clr_count), .edge_total(edge_total)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something blocks forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [LANES*GRAD_W-1:0] lanes11(input int a, input int b, input int c, input int d);
    return {11'(d), 11'(c), 11'(b), 11'(a)};
  endfunction

  function automatic logic [LANES*OUT_W-1:0] pix4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int satAdd(input int a, input int b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  function automatic int streamEdges(input int b);
    int n;
    n = 0;
    for (int i = 0; i < LANES; i++) if (b * 10 + i > 50) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns one step after the accepting edge.
  task automatic applyStimulus(input logic [LANES*GRAD_W-1:0] vx, input logic [LANES*GRAD_W-1:0] vy,
                               input logic [OUT_W-1:0] thr, input logic [1:0] md);
    int n;
    gx = vx; gy = vy; threshold = thr; mode = md; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      step;
      n++;
    end
    if (!in_ready) checkOutput("acceptTimeout", 64'(in_ready), 64'd1);
    step;
    in_valid = 1'b0;
  endtask

  // Main sequence.
  initial begin
    logic [LANES*OUT_W-1:0] heldPix;
    logic heldValid;
    logic sawBlock;
    int sent;
    int rcvd;

    vecs[0] = '{lanes11(-1024, -1024, -1024, -1024), lanes11(-1024, -1024, -1024, -1024), 8'd0, 2'b00, pix4(255, 255, 255, 255), 3'd4};
    vecs[1] = '{lanes11(150, 100, 0, -200), lanes11(0, 51, 0, 55), 8'd150, 2'b01, pix4(0, 255, 0, 255), 3'd2};
    vecs[2] = '{lanes11(-60, 1023, 30, 0), lanes11(50, -1024, -20, -101), 8'd100, 2'b10, pix4(110, 255, 0, 101), 3'd3};
    vecs[3] = '{lanes11(200, -128, 255, 0), lanes11(54, -128, 0, 0), 8'd255, 2'b11, pix4(254, 255, 255, 0), 3'd1};
    vecs[4] = '{lanes11(-5, -3, 11, -1023), lanes11(0, 7, 0, 0), 8'd10, 2'b00, pix4(5, 10, 11, 255), 3'd2};
    vecs[5] = '{lanes11(0, 1, 0, -1024), lanes11(0, 0, 0, 0), 8'd0, 2'b01, pix4(0, 255, 0, 255), 3'd2};
    vecs[6] = '{lanes11(-128, 255, -1024, 150), lanes11(-128, 0, -1024, -150), 8'd255, 2'b10, pix4(255, 0, 255, 255), 3'd3};

    n_rst = 1'b0; in_valid = 1'b0; gx = '0; gy = '0; threshold = '0; mode = '0;
    out_ready = 1'b1; clr_count = 1'b0;
    #12;
    checkOutput("rstOutValid", 64'(out_valid), 64'd0);
    checkOutput("rstPix", 64'(pix_out), 64'd0);
    checkOutput("rstEdges", 64'(beat_edges), 64'd0);
    checkOutput("rstTotal", 64'(edge_total), 64'd0);
    step;
    n_rst = 1'b1;
    #1;
    checkOutput("rstInReady", 64'(in_ready), 64'd1);

    // Single-beat vectors: latency, pixels, popcount, running total.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].gx, vecs[v].gy, vecs[v].thr, vecs[v].mode);
      checkOutput($sformatf("vec%0d early", v), 64'(out_valid), 64'd0);
      step;
      checkOutput($sformatf("vec%0d valid", v), 64'(out_valid), 64'd1);
      checkOutput($sformatf("vec%0d pix", v), 64'(pix_out), 64'(vecs[v].pix));
      checkOutput($sformatf("vec%0d edges", v), 64'(beat_edges), 64'(vecs[v].edges));
      step;
      expTotal = satAdd(expTotal, int'(vecs[v].edges));
      checkOutput($sformatf("vec%0d total", v), 64'(edge_total), 64'(expTotal));
    end

    // Stream 10 beats with a 3-cycle downstream stall.
    sent = 0; rcvd = 0; heldValid = 1'b0; heldPix = '0; sawBlock = 1'b0;
    for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (sent < 10) begin
        gx = lanes11(sent * 10, sent * 10 + 1, sent * 10 + 2, sent * 10 + 3);
        gy = '0; threshold = 8'd50; mode = 2'b00; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) sawBlock = 1'b1;
      if (heldValid) checkOutput("stallStable", 64'(pix_out), 64'(heldPix));
      heldValid = out_valid && !out_ready;
      heldPix = pix_out;
      if (out_valid && out_ready) begin
        checkOutput("streamPix", 64'(pix_out), 64'(pix4(rcvd * 10, rcvd * 10 + 1, rcvd * 10 + 2, rcvd * 10 + 3)));
        checkOutput("streamEdges", 64'(beat_edges), 64'(streamEdges(rcvd)));
        expTotal = satAdd(expTotal, streamEdges(rcvd));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      step;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("streamCount", 64'(rcvd), 64'd10);
    checkOutput("inReadyDrop", 64'(sawBlock), 64'd1);
    checkOutput("streamTotal", 64'(edge_total), 64'(expTotal));

    // Threshold/mode change right after acceptance must not affect the beat.
    applyStimulus(lanes11(50, 150, 100, 101), lanes11(0, 0, 0, 0), 8'd100, 2'b01);
    threshold = 8'd0; mode = 2'b00;
    step;
    checkOutput("lateCfgPix", 64'(pix_out), 64'(pix4(0, 255, 0, 255)));
    checkOutput("lateCfgEdges", 64'(beat_edges), 64'd2);
    step;
    expTotal = satAdd(expTotal, 2);
    checkOutput("lateCfgTotal", 64'(edge_total), 64'(expTotal));

    // Reset with two beats in flight.
    out_ready = 1'b0;
    applyStimulus(lanes11(10, 20, 30, 40), lanes11(0, 0, 0, 0), 8'd0, 2'b00);
    applyStimulus(lanes11(11, 21, 31, 41), lanes11(0, 0, 0, 0), 8'd0, 2'b00);
    checkOutput("preRstValid", 64'(out_valid), 64'd1);
    n_rst = 1'b0;
    #1;
    checkOutput("midRstValid", 64'(out_valid), 64'd0);
    checkOutput("midRstPix", 64'(pix_out), 64'd0);
    checkOutput("midRstEdges", 64'(beat_edges), 64'd0);
    checkOutput("midRstTotal", 64'(edge_total), 64'd0);
    step;
    n_rst = 1'b1;
    #1;
    checkOutput("postRstInReady", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step;
    step;
    checkOutput("postRstNoGhost", 64'(out_valid), 64'd0);
    expTotal = 0;

    // Drive the counter into saturation with 4-edge beats.
    for (int k = 0; k < 17; k++) begin
      applyStimulus(lanes11(5, 5, 5, 5), lanes11(0, 0, 0, 0), 8'd0, 2'b00);
      step;
      step;
      expTotal = satAdd(expTotal, 4);
      checkOutput($sformatf("satTotal%0d", k), 64'(edge_total), 64'(expTotal));
    end

    // Clear coinciding with a handshake loads that beat's edge count.
    out_ready = 1'b0;
    applyStimulus(lanes11(5, 5, 0, 0), lanes11(0, 0, 0, 0), 8'd0, 2'b00);
    step;
    checkOutput("clrHsValid", 64'(out_valid), 64'd1);
    clr_count = 1'b1;
    out_ready = 1'b1;
    step;
    clr_count = 1'b0;
    checkOutput("clrHsTotal", 64'(edge_total), 64'd2);

    // Clear without a handshake zeroes the count.
    clr_count = 1'b1;
    step;
    clr_count = 1'b0;
    checkOutput("clrAloneTotal", 64'(edge_total), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
